int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller_pkg.sv | 19 +
 rtl/int_controller_if.sv | 31 +++
 rtl/int_controller_prio_enc.sv | 27 ++
 rtl/int_controller.sv | 121 ++++++++++++
 tb/tb_int_controller.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/int_controller_pkg.sv
// Shared types and defaults for the interrupt controller: FSM state encoding,
// default sizing constants and the vector-width helper.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    localparam int DEF_NUM_IRQ   = 8;
    localparam int DEF_NMI_WIDTH = 4;

    // A single request line still needs a 1-bit vector port.
    function automatic int vec_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_controller_if.sv
// CPU/device-side signal bundle of the interrupt controller; master drives
// requests and CPU handshakes, slave is the controller itself.
interface int_controller_if
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ
);
    localparam int VW = vec_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq;
    logic               nmi_req;
    logic               cfg_we;
    logic [NUM_IRQ-1:0] cfg_mask;
    logic               eoi;
    logic               INA;
    logic               INT;
    logic               NMI;
    logic [VW-1:0]      vector;
    logic               busy;

    modport master (
        output irq, nmi_req, cfg_we, cfg_mask, eoi, INA,
        input  INT, NMI, vector, busy
    );

    modport slave (
        input  irq, nmi_req, cfg_we, cfg_mask, eoi, INA,
        output INT, NMI, vector, busy
    );

endinterface

// File: rtl/int_controller_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req_i and whether
// any bit is set at all.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_NUM_IRQ,
    localparam int IW   = vec_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IW-1:0]    index_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        index_o = '0;
        valid_o = 1'b0;
        // Scanning downwards lets the last hit, the lowest index, win.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Edge-triggered maskable interrupt controller with a fixed-width NMI pulse
// generator and an IDLE/REQ/SERV request-acknowledge-EOI handshake.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ   = DEF_NUM_IRQ,
    parameter int NMI_WIDTH = DEF_NMI_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    int_controller_if.slave    bus
);

    localparam int VW = vec_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, mask_q, isr_q, isr_d;
    logic [NUM_IRQ-1:0] irq_edge, pend_clr, eligible;
    logic               nmi_q, ina_q, armed_q;
    logic               nmi_edge, ina_edge;
    logic [3:0]         nmi_cnt_q, nmi_cnt_d;
    logic               nmi_out_q, nmi_out_d;
    logic               int_q, int_d;
    state_t             state_q, state_d;
    logic [VW-1:0]      vector_q, vector_d, top_idx;
    logic               top_valid;

    // Edges are suppressed until the edge registers have reloaded once after
    // reset, so inputs held high across release do not fire.
    assign irq_edge = armed_q ? (bus.irq & ~irq_q) : '0;
    assign nmi_edge = armed_q & bus.nmi_req & ~nmi_q;
    assign ina_edge = armed_q & bus.INA & ~ina_q;
    assign eligible = pending_q & ~mask_q;

    prio_enc #(.WIDTH(NUM_IRQ)) u_prio_enc (
        .req_i   (eligible),
        .index_o (top_idx),
        .valid_o (top_valid)
    );

    always_comb begin
        if (nmi_cnt_q != 4'd0) begin
            nmi_cnt_d = nmi_cnt_q - 4'd1;
        end else if (nmi_edge) begin
            nmi_cnt_d = 4'(NMI_WIDTH);
        end else begin
            nmi_cnt_d = 4'd0;
        end
        nmi_out_d = (nmi_cnt_d != 4'd0);
    end

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        isr_d    = isr_q;
        pend_clr = '0;
        case (state_q)
            IDLE: begin
                if (top_valid && !nmi_out_q) begin
                    state_d  = REQ;
                    vector_d = top_idx;
                end
            end
            REQ: begin
                if (ina_edge) begin
                    state_d            = SERV;
                    pend_clr[vector_q] = 1'b1;
                    isr_d[vector_q]    = 1'b1;
                end else if (mask_q[vector_q]) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (bus.eoi && isr_q[vector_q]) begin
                    isr_d[vector_q] = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge on a line being cleared this cycle keeps it pending.
        pending_d = (pending_q & ~pend_clr) | irq_edge;
        int_d     = (state_d == REQ) && !nmi_out_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            nmi_q     <= 1'b0;
            ina_q     <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            isr_q     <= '0;
            mask_q    <= '1;
            nmi_cnt_q <= 4'd0;
            nmi_out_q <= 1'b0;
            int_q     <= 1'b0;
            state_q   <= IDLE;
            vector_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            irq_q     <= bus.irq;
            nmi_q     <= bus.nmi_req;
            ina_q     <= bus.INA;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            if (bus.cfg_we) mask_q <= bus.cfg_mask;
            nmi_cnt_q <= nmi_cnt_d;
            nmi_out_q <= nmi_out_d;
            int_q     <= int_d;
            state_q   <= state_d;
            vector_q  <= vector_d;
        end
    end

    assign bus.INT    = int_q;
    assign bus.NMI    = nmi_out_q;
    assign bus.vector = vector_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_int_controller.sv
// Directed and randomized checks of int_controller against a behavioural
// request/acknowledge/NMI model.
module tb_int_controller;

    localparam int N = 8;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int_controller_if #(.NUM_IRQ(N)) bus ();

    int_controller #(.NUM_IRQ(N), .NMI_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: requests as a bit array, a phase number
    // (0 idle, 1 waiting for ack, 2 in service), and a remaining-NMI count.
    bit mp[N];
    bit mm[N];
    bit pi[N];
    bit pn, pa, m_arm;
    int m_phase, m_vec, m_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mp[i] = 1'b0;
            mm[i] = 1'b1;
            pi[i] = 1'b0;
        end
        pn = 1'b0; pa = 1'b0; m_arm = 1'b0;
        m_phase = 0; m_vec = 0; m_left = 0;
    endtask

    task automatic model_step();
        bit e[N];
        bit ne, ae, nmi_now;
        int lowest;
        nmi_now = (m_left > 0);
        for (int i = 0; i < N; i++) e[i] = m_arm && bus.irq[i] && !pi[i];
        ne = m_arm && bus.nmi_req && !pn;
        ae = m_arm && bus.INA && !pa;
        lowest = -1;
        for (int i = N - 1; i >= 0; i--) if (mp[i] && !mm[i]) lowest = i;
        if (m_phase == 0) begin
            if (lowest >= 0 && !nmi_now) begin
                m_phase = 1;
                m_vec   = lowest;
            end
        end else if (m_phase == 1) begin
            if (ae) begin
                m_phase   = 2;
                mp[m_vec] = 1'b0;
            end else if (mm[m_vec]) begin
                m_phase = 0;
            end
        end else if (bus.eoi) begin
            m_phase = 0;
        end
        for (int i = 0; i < N; i++) if (e[i]) mp[i] = 1'b1;
        if (bus.cfg_we) for (int i = 0; i < N; i++) mm[i] = bus.cfg_mask[i];
        if (m_left > 0) m_left--;
        else if (ne) m_left = W;
        for (int i = 0; i < N; i++) pi[i] = bus.irq[i];
        pn = bus.nmi_req;
        pa = bus.INA;
        m_arm = 1'b1;
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mp[i];
        return v;
    endfunction

    // One clock: advance the model on the applied inputs, then compare
    // DUT outputs 1 time unit after the edge.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, " INT"},    32'(bus.INT),    32'(m_phase == 1 && m_left == 0));
        check({tag, " NMI"},    32'(bus.NMI),    32'(m_left > 0));
        check({tag, " busy"},   32'(bus.busy),   32'(m_phase != 0));
        check({tag, " vector"}, 32'(bus.vector), 32'(m_vec));
        check({tag, " pend"},   32'(dut.pending_q), 32'(model_pending()));
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        bus.cfg_we = 1'b1; bus.cfg_mask = m;
        step("mask");
        bus.cfg_we = 1'b0;
    endtask

    task automatic ack_and_eoi();
        bus.INA = 1'b1; step("ack");
        bus.INA = 1'b0; bus.eoi = 1'b1; step("eoi");
        bus.eoi = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.irq = '0; bus.nmi_req = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_mask = '0; bus.eoi = 1'b0; bus.INA = 1'b0;
        model_reset();
        #12;
        check("rst INT", 32'(bus.INT), 32'd0);
        check("rst NMI", 32'(bus.NMI), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst vector", 32'(bus.vector), 32'd0);
        check("rst mask", 32'(dut.mask_q), 32'hFF);
        rst_n = 1'b1;
        step("arm");

        // Single request, acknowledge and end-of-interrupt.
        write_mask(8'h00);
        bus.irq[5] = 1'b1; step("i5 edge");
        check("i5 int early", 32'(bus.INT), 32'd0);
        bus.irq[5] = 1'b0; step("i5 req");
        check("i5 int", 32'(bus.INT), 32'd1);
        check("i5 vec", 32'(bus.vector), 32'd5);
        bus.INA = 1'b1; step("i5 ack");
        check("i5 int after ack", 32'(bus.INT), 32'd0);
        check("i5 pend clr", 32'(dut.pending_q[5]), 32'd0);
        bus.INA = 1'b0; bus.eoi = 1'b1; step("i5 eoi");
        bus.eoi = 1'b0;
        check("i5 busy", 32'(bus.busy), 32'd0);

        // Simultaneous edges: lowest index first.
        bus.irq = 8'h44; step("dual edge");
        bus.irq = 8'h00; step("dual req");
        check("dual first", 32'(bus.vector), 32'd2);
        ack_and_eoi();
        step("dual next");
        check("dual second", 32'(bus.vector), 32'd6);
        check("dual second int", 32'(bus.INT), 32'd1);
        ack_and_eoi();

        // Masked line waits until unmasked.
        write_mask(8'h08);
        bus.irq[3] = 1'b1; step("m3 edge");
        bus.irq[3] = 1'b0;
        for (int k = 0; k < 3; k++) step("m3 hold");
        check("m3 masked", 32'(bus.INT), 32'd0);
        write_mask(8'h00);
        step("m3 unmask");
        check("m3 int", 32'(bus.INT), 32'd1);
        check("m3 vec", 32'(bus.vector), 32'd3);
        ack_and_eoi();

        // NMI pulse during REQ.
        bus.irq[1] = 1'b1; step("n1 edge");
        bus.irq[1] = 1'b0; step("n1 req");
        bus.nmi_req = 1'b1; step("nmi 1");
        bus.nmi_req = 1'b0;
        check("nmi hi", 32'(bus.NMI), 32'd1);
        check("nmi int low", 32'(bus.INT), 32'd0);
        for (int k = 0; k < W - 1; k++) step("nmi pulse");
        check("nmi still hi", 32'(bus.NMI), 32'd1);
        step("nmi done");
        check("nmi low", 32'(bus.NMI), 32'd0);
        check("nmi int back", 32'(bus.INT), 32'd1);
        check("nmi vec", 32'(bus.vector), 32'd1);

        // Asynchronous reset in the middle of service, irq held high.
        bus.INA = 1'b1; step("r ack");
        bus.INA = 1'b0;
        bus.irq[4] = 1'b1; step("r irq");
        #2 rst_n = 1'b0;
        #1;
        check("ar INT", 32'(bus.INT), 32'd0);
        check("ar NMI", 32'(bus.NMI), 32'd0);
        check("ar busy", 32'(bus.busy), 32'd0);
        check("ar vector", 32'(bus.vector), 32'd0);
        model_reset();
        #10 rst_n = 1'b1;
        step("post rst");
        write_mask(8'h00);
        for (int k = 0; k < 3; k++) step("held irq");
        check("held no int", 32'(bus.INT), 32'd0);
        bus.irq[4] = 1'b0; step("i4 low");
        bus.irq[4] = 1'b1; step("i4 edge");
        step("i4 req");
        check("i4 int", 32'(bus.INT), 32'd1);
        check("i4 vec", 32'(bus.vector), 32'd4);
        bus.irq[4] = 1'b0;

        // Stray eoi in REQ, stray INA in IDLE.
        bus.eoi = 1'b1; step("stray eoi");
        bus.eoi = 1'b0;
        check("stray eoi busy", 32'(bus.busy), 32'd1);
        ack_and_eoi();
        bus.INA = 1'b1; step("stray ina");
        bus.INA = 1'b0;
        check("stray ina busy", 32'(bus.busy), 32'd0);

        // Everything pending, everything masked.
        write_mask(8'hFF);
        bus.irq = 8'hFF; step("all edge");
        bus.irq = 8'h00;
        for (int k = 0; k < 4; k++) step("all masked");
        check("all pend", 32'(dut.pending_q), 32'hFF);
        check("all no int", 32'(bus.INT), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.irq      = bus.irq ^ (N'($urandom) & N'($urandom));
            bus.nmi_req  = ($urandom_range(0, 15) == 0);
            bus.INA      = ($urandom_range(0, 3) == 0);
            bus.eoi      = ($urandom_range(0, 5) == 0);
            bus.cfg_we   = ($urandom_range(0, 31) == 0);
            bus.cfg_mask = N'($urandom) & N'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
